// File: rtl/tx_frame_buffer.sv
// Ping-pong frame buffer feeding the RGMII transmitter.
// Packs a byte stream into one RAM half while the reader owns the other half.
module tx_frame_buffer #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MIN_GAP  = 1072,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic              idx,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [7:0]        rd_data,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        FILL,
        PAD,
        WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [15:0]       GAP_MAX = 16'(MIN_GAP);
    localparam logic [15:0]       GAP_ARM = 16'(MIN_GAP - 1);

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [15:0]       gap_cnt;
    logic [7:0]        ram [0:2**(ADDR_W+1)-1];

    logic       wr_en;
    logic [7:0] wr_byte;
    logic       at_last;
    logic       gap_ok;

    assign wr_en   = (s_valid && s_ready) || (state == PAD);
    assign wr_byte = (state == PAD) ? PAD_BYTE : s_data;
    assign at_last = (wptr == LAST);
    // Counter reaches MIN_GAP on this very edge, so toggles land MIN_GAP apart.
    assign gap_ok  = (gap_cnt >= GAP_ARM);

    always_ff @(posedge clk125) begin
        if (wr_en) begin
            ram[{~idx, wptr}] <= wr_byte;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= ram[rd_addr];
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            s_ready   <= 1'b1;
            idx       <= 1'b0;
            wptr      <= '0;
            frame_cnt <= '0;
            gap_cnt   <= GAP_MAX;
        end else begin
            if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + 16'd1;
            end
            unique case (state)
                FILL: begin
                    if (s_valid) begin
                        if (at_last) begin
                            state   <= WAIT;
                            s_ready <= 1'b0;
                        end else begin
                            wptr <= wptr + 1'b1;
                            if (s_last) begin
                                state   <= PAD;
                                s_ready <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (at_last) begin
                        state <= WAIT;
                    end else begin
                        wptr <= wptr + 1'b1;
                    end
                end
                WAIT: begin
                    if (gap_ok) begin
                        idx       <= ~idx;
                        wptr      <= '0;
                        gap_cnt   <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= FILL;
                        s_ready   <= 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer: directed frame table, random frames,
// and a mid-PAD asynchronous reset, checked against a frame-level model.
module tb_tx_frame_buffer;

    localparam int MIN_GAP = 1072;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    logic        clk125 = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic        idx;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] frame_cnt;

    tx_frame_buffer #(
        .ADDR_W  (10),
        .MIN_GAP (MIN_GAP),
        .PAD_BYTE(PAD_BYTE)
    ) dut (
        .clk125   (clk125),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .idx      (idx),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .frame_cnt(frame_cnt)
    );

    always #4 clk125 = ~clk125;

    int cyc = 0;
    always @(posedge clk125) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference state
    logic [7:0] exp_mem [0:2047];
    bit         have_prev;
    int         prev_t;
    bit         exp_idx_m;
    int         exp_cnt_m;

    typedef struct {
        int len;
        int vmode;
        bit last_end;
        bit dmode;
        bit readback;
        int exp_delay;
        int exp_space;
        bit exp_idx;
        int exp_cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_frame(input int len, input int vmode, input bit last_end,
                            input bit dmode, input bit want_toggle,
                            output int last_edge, output int t_edge);
        logic [7:0] fb [0:1023];
        int k, guard, bad, pad, exp_t;
        bit v, acc;
        logic old;
        for (int i = 0; i < len; i++) fb[i] = dmode ? 8'($urandom) : 8'(i);
        k = 0;
        guard = 0;
        bad = 0;
        last_edge = -1;
        t_edge = -1;
        while (k < len && guard < 8000) begin
            case (vmode)
                0: v = 1'b1;
                1: v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            s_data  = v ? fb[k] : 8'($urandom);
            s_last  = v ? (k == len - 1 && last_end) : 1'($urandom_range(0, 1));
            if (s_ready !== 1'b1) bad++;
            acc = v && (s_ready === 1'b1);
            tick();
            if (acc) begin
                k++;
                last_edge = cyc;
            end
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("accept_count", k, len);
        check("ready_in_fill", bad, 0);
        if (!want_toggle) return;

        pad = (last_end && len < 1024) ? 1024 - len : 0;
        exp_t = last_edge + pad + 1;
        if (have_prev && prev_t + MIN_GAP > exp_t) exp_t = prev_t + MIN_GAP;

        // Present a byte that must not be taken during PAD/WAIT
        old = idx;
        bad = 0;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        for (int g = 0; g < 4000; g++) begin
            if (idx !== old) begin
                t_edge = cyc;
                break;
            end
            if (s_ready !== 1'b0) bad++;
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("toggle_edge", t_edge, exp_t);
        check("ready_low_to_swap", bad, 0);
        check("ready_after_swap", s_ready, 1);
        exp_idx_m = !exp_idx_m;
        exp_cnt_m++;
        check("idx", idx, exp_idx_m);
        check("frame_cnt", frame_cnt, exp_cnt_m & 16'hFFFF);
        for (int i = 0; i < 1024; i++)
            exp_mem[(exp_idx_m ? 1024 : 0) + i] = (i < len) ? fb[i] : PAD_BYTE;
        have_prev = 1'b1;
        prev_t = t_edge;
    endtask

    task automatic read_half(input bit h);
        int mism;
        mism = 0;
        s_valid = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            rd_addr = {h, 10'(k)};
            tick();
            if (rd_data !== exp_mem[(h ? 1024 : 0) + k]) mism++;
        end
        check(h ? "readback_half1" : "readback_half0", mism, 0);
    endtask

    initial begin
        int le, te, pt, len;
        bit le_flag;

        tbl[0] = '{1024, 0, 1'b0, 1'b0, 1'b0, 1,   0,    1'b1, 1};
        tbl[1] = '{1024, 0, 1'b0, 1'b1, 1'b1, 0,   1072, 1'b0, 2};
        tbl[2] = '{100,  0, 1'b1, 1'b1, 1'b1, 925, 0,    1'b1, 3};
        tbl[3] = '{1024, 0, 1'b1, 1'b1, 1'b1, 1,   0,    1'b0, 4};
        tbl[4] = '{1024, 1, 1'b0, 1'b1, 1'b1, 1,   0,    1'b1, 5};

        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
        rd_addr = '0;
        have_prev = 1'b0;
        prev_t = 0;
        exp_idx_m = 1'b0;
        exp_cnt_m = 0;

        #21;
        check("reset_s_ready", s_ready, 1);
        check("reset_idx", idx, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_rd_data", rd_data, 0);
        @(posedge clk125);
        #3 rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            pt = prev_t;
            do_frame(tbl[i].len, tbl[i].vmode, tbl[i].last_end, tbl[i].dmode,
                     1'b1, le, te);
            if (tbl[i].exp_delay != 0)
                check("swap_delay", te - le, tbl[i].exp_delay);
            if (tbl[i].exp_space != 0)
                check("swap_spacing", te - pt, tbl[i].exp_space);
            check("tbl_idx", idx, tbl[i].exp_idx);
            check("tbl_frame_cnt", frame_cnt, tbl[i].exp_cnt);
            if (tbl[i].readback) begin
                read_half(1'b0);
                read_half(1'b1);
            end
        end

        for (int r = 0; r < 6; r++) begin
            len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40))
                                              : int'($urandom_range(900, 1024));
            le_flag = (len < 1024) ? 1'b1 : 1'($urandom_range(0, 1));
            do_frame(len, int'($urandom_range(0, 2)), le_flag, 1'b1, 1'b1, le, te);
            if ($urandom_range(0, 1) != 0) begin
                read_half(1'b0);
                read_half(1'b1);
            end
        end

        if (idx !== 1'b1) do_frame(1024, 0, 1'b0, 1'b1, 1'b1, le, te);
        do_frame(50, 0, 1'b1, 1'b1, 1'b0, le, te);
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_idx", idx, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (3) tick();
        check("rst_no_toggle", idx, 0);
        #2 rst = 1'b0;
        tick();
        have_prev = 1'b0;
        exp_idx_m = 1'b0;
        exp_cnt_m = 0;
        do_frame(1024, 0, 1'b0, 1'b1, 1'b1, le, te);
        check("post_rst_delay", te - le, 1);
        read_half(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_frame_buffer.md
Name: tx_frame_buffer

Overview:
- Upstream stage of the RGMII Ethernet transmitter.
- Accepts a byte stream with a valid/ready handshake and packs it into a 2 x 1024-byte ping-pong RAM.
- Toggles `idx` when a half is complete. The transmitter detects the `idx` edge, reads that half through `rd_addr`/`rd_data`, and sends one 1024-byte payload frame.
- Enforces a minimum spacing between swaps, so a half is never overwritten while the transmitter is still reading it.

Parameters:
- ADDR_W, 10: byte-address width of one half. Half size is 2**ADDR_W bytes; the RAM is 2**(ADDR_W+1) x 8.
- MIN_GAP, 1072: minimum clk125 cycles between consecutive `idx` toggles. Covers frame (1052) + IFG (12) + pipeline margin. Must be < 65536.
- PAD_BYTE, 8'h00: fill value used when a frame is closed early by `s_last`.

Ports:
- clk125  in  1  125 MHz clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  input payload byte.
- s_valid  in  1  `s_data` is valid.
- s_ready  out  1  block accepts a byte this cycle; high only in FILL.
- s_last  in  1  with an accepted byte: close the frame and pad the remainder.
- idx  out  1  half currently owned by the reader; toggles once per completed frame.
- rd_addr  in  ADDR_W+1  read address, {half, offset}, from the transmitter.
- rd_data  out  8  RAM[rd_addr], registered, valid 1 cycle after `rd_addr` is sampled.
- frame_cnt  out  16  number of swaps since reset; wraps at 65535 -> 0.

Behaviour:
- Reset values (async, immediate on `rst`):
  - state=FILL, `idx`=0, `wptr`=0, `frame_cnt`=0, `rd_data`=0.
  - `gap_cnt`=MIN_GAP, so the first swap is not delayed.
  - RAM contents are not cleared.
- Write address is {~idx, wptr}. The writer only ever writes the half the reader does not own.
- Read port is independent of writes. Simultaneous read and write to the same address is impossible by construction (halves differ).
- `gap_cnt` (16 bit):
  - Cleared to 0 on the edge `idx` toggles.
  - Otherwise increments by 1 per cycle, saturating at MIN_GAP.
- State FILL, `s_ready`=1:
  - Handshake: on `s_valid`&&`s_ready`, write `s_data` at `wptr`, then `wptr`++.
  - If the written offset is 2**ADDR_W-1, go to WAIT. This applies regardless of `s_last`; no padding occurs.
  - Else if `s_last`=1, go to PAD. `wptr` now points at the next offset.
  - `s_valid`=0: nothing changes; `s_ready` stays 1.
- State PAD, `s_ready`=0:
  - Each cycle, write PAD_BYTE at `wptr`, then `wptr`++.
  - After writing offset 2**ADDR_W-1, go to WAIT.
- State WAIT, `s_ready`=0:
  - On the first edge where `gap_cnt`==MIN_GAP: toggle `idx`, set `wptr`=0, clear `gap_cnt`, `frame_cnt`++, go to FILL.
- Swap latency:
  - Last byte written at edge N. Earliest `idx` toggle is edge N+1.
  - Earliest next accepted byte is at edge N+2.
- Swap spacing: consecutive `idx` toggles are always >= MIN_GAP cycles apart.
- `wptr` is ADDR_W bits wide and never wraps inside a half; it is reset to 0 only at a swap.
- `s_last` is ignored when `s_valid`=0 or `s_ready`=0.
- A byte presented in WAIT or PAD is not accepted. The source must hold it until `s_ready` is high.
- Reset asserted mid-FILL, PAD or WAIT:
  - The partial frame is discarded and no toggle is produced.
  - After deassert, the block behaves as after power-up.

Test Plan:
1. Reset, then 1024 bytes with `s_valid` held high, data=offset[7:0]:
   - `s_ready` falls after the 1024th accept.
   - `idx` goes 0->1 exactly 1 cycle later; `frame_cnt`=1.
   - Reading `rd_addr`=0x400+k returns k[7:0], one cycle after the address.
2. Immediately send a second 1024-byte frame:
   - Second `idx` toggle (1->0) occurs exactly MIN_GAP=1072 cycles after the first.
   - Half 0 holds the new data; half 1 is unchanged throughout.
3. Frame of 100 bytes with `s_last` on byte 99:
   - 924 PAD cycles follow with `s_ready`=0.
   - Offsets 100..1023 read 0x00; offsets 0..99 read the input data.
   - `idx` toggles 1 cycle after the pad write at offset 1023.
4. `s_last` asserted with the 1024th byte -> no PAD cycles; toggle timing identical to test 1.
5. `s_valid` toggled every other cycle for a full frame:
   - `s_ready` stays 1.
   - Exactly 1024 writes occur, at consecutive offsets with no gaps or duplicates.
6. Assert `rst` in the middle of PAD (after 50 data bytes), asynchronously between edges:
   - `s_ready`, `idx` and `frame_cnt` return to 1/0/0 immediately, with no toggle.
   - A following full 1024-byte frame toggles `idx` 1 cycle after its last byte.
